chain_code_tracer: RTL and testbench

- Parametrised successor to the fixed 64x64 chain-code encoder.
- Raster-scans a binary image through a one-cycle-latency pixel read port and finds the first object pixel.
- Traces that object's outer border with 8-connected Freeman codes, streamed out over a valid/ready handshake.
- Reports start pixel, perimeter (code count) and shoelace area of the border path; sits between the frame buffer and the shape-descriptor stage.

---
 rtl/chain_code_tracer.sv | 220 ++++++++++++++++++++++
 tb/tb_chain_code_tracer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_code_tracer.sv
`default_nettype none
// ============================================================================
// Module      : chain_code_tracer
// Description : Raster-scans a binary image for the first object pixel, then
//               traces its outer border as 8-connected Freeman codes streamed
//               over valid/ready. Reports start pixel, perimeter and area.
//               Optional area logic enabled by defining CC_AREA_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module chain_code_tracer #(
    parameter int XW = 6,
    parameter int YW = 6,
    parameter int PW = 8,
    parameter int AW = 12
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    output logic [YW+XW-1:0]  pix_addr,
    output logic              pix_rd,
    input  logic              pix_data,
    output logic [2:0]        Code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [XW-1:0]     start_x,
    output logic [YW-1:0]     start_y,
    output logic [AW-1:0]     Area,
    output logic [PW-1:0]     Perimiter,
    output logic              Done,
    output logic              Error
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SCAN_RD  = 3'd1;
    localparam logic [2:0] c_SCAN_CHK = 3'd2;
    localparam logic [2:0] c_TR_RD    = 3'd3;
    localparam logic [2:0] c_TR_CHK   = 3'd4;
    localparam logic [2:0] c_EMIT     = 3'd5;
    localparam logic [2:0] c_DONE     = 3'd6;
    localparam logic [2:0] c_ERR      = 3'd7;

    localparam logic [XW-1:0] c_X_MAX = '1;
    localparam logic [YW-1:0] c_Y_MAX = '1;
    localparam logic [PW-1:0] c_P_MAX = '1;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic [2:0]    r_s;
    logic [2:0]    r_nbg;
    logic [2:0]    r_code;
    logic [PW-1:0] r_perim;
    logic          w_xp, w_xn, w_yp, w_yn;
    logic          w_inb, w_hit, w_at_start, w_last_px;

    // Unit step of the current search direction (y grows downward)
    always_comb begin
        w_xp = (r_s == 3'd0) || (r_s == 3'd1) || (r_s == 3'd7);
        w_xn = (r_s == 3'd3) || (r_s == 3'd4) || (r_s == 3'd5);
        w_yn = (r_s == 3'd1) || (r_s == 3'd2) || (r_s == 3'd3);
        w_yp = (r_s == 3'd5) || (r_s == 3'd6) || (r_s == 3'd7);
    end

    assign w_inb = !((w_xp && (r_x == c_X_MAX)) || (w_xn && (r_x == '0)) ||
                     (w_yp && (r_y == c_Y_MAX)) || (w_yn && (r_y == '0)));
    assign w_nx  = w_xp ? r_x + XW'(1) : (w_xn ? r_x - XW'(1) : r_x);
    assign w_ny  = w_yp ? r_y + YW'(1) : (w_yn ? r_y - YW'(1) : r_y);

    assign w_hit      = (r_state == c_TR_CHK) && w_inb && pix_data;
    assign w_at_start = (r_x == start_x) && (r_y == start_y);
    assign w_last_px  = (r_x == c_X_MAX) && (r_y == c_Y_MAX);

    assign code_valid = (r_state == c_EMIT);
    assign Done       = (r_state == c_DONE);
    assign Error      = (r_state == c_ERR);
    assign Code       = r_code;
    assign Perimiter  = r_perim;

    // Out-of-image probes spend their slot without touching the frame buffer
    always_comb begin
        pix_rd   = 1'b0;
        pix_addr = '0;
        if (r_state == c_SCAN_RD) begin
            pix_rd   = 1'b1;
            pix_addr = {r_y, r_x};
        end else if ((r_state == c_TR_RD) && w_inb) begin
            pix_rd   = 1'b1;
            pix_addr = {w_ny, w_nx};
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:     if (start) w_state_nxt = c_SCAN_RD;
            c_SCAN_RD:  w_state_nxt = c_SCAN_CHK;
            c_SCAN_CHK: begin
                if (pix_data)       w_state_nxt = c_TR_RD;
                else if (w_last_px) w_state_nxt = c_ERR;
                else                w_state_nxt = c_SCAN_RD;
            end
            c_TR_RD:    w_state_nxt = c_TR_CHK;
            c_TR_CHK: begin
                if (w_hit)                w_state_nxt = (r_perim == c_P_MAX) ? c_ERR : c_EMIT;
                else if (r_nbg == 3'd7)   w_state_nxt = c_DONE;
                else                      w_state_nxt = c_TR_RD;
            end
            c_EMIT: begin
                if (code_ready) w_state_nxt = w_at_start ? c_DONE : c_TR_RD;
            end
            c_DONE:     if (!start) w_state_nxt = c_IDLE;
            c_ERR:      if (!start) w_state_nxt = c_IDLE;
            default:    w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_nbg   <= '0;
            r_code  <= '0;
            r_perim <= '0;
            start_x <= '0;
            start_y <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_perim <= '0;
                    end
                end
                c_SCAN_CHK: begin
                    if (pix_data) begin
                        start_x <= r_x;
                        start_y <= r_y;
                        r_s     <= 3'd5;
                        r_nbg   <= '0;
                    end else begin
                        r_x <= r_x + XW'(1);
                        if (r_x == c_X_MAX) r_y <= r_y + YW'(1);
                    end
                end
                c_TR_CHK: begin
                    if (w_hit) begin
                        r_code <= r_s;
                        r_x    <= w_nx;
                        r_y    <= w_ny;
                        // Back off to the first neighbour not yet known to be background
                        r_s    <= r_s + (r_s[0] ? 3'd6 : 3'd7);
                        r_nbg  <= '0;
                    end else begin
                        r_s   <= r_s + 3'd1;
                        r_nbg <= r_nbg + 3'd1;
                    end
                end
                c_EMIT: begin
                    if (code_ready) r_perim <= r_perim + PW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CC_AREA_EN
    localparam int c_ACCW = AW + XW + YW;

    logic signed [c_ACCW-1:0] r_acc;
    logic signed [c_ACCW-1:0] w_xe, w_ye, w_dacc;
    logic        [c_ACCW-1:0] w_abs;
    logic        [AW-1:0]     r_area;

    assign w_xe = $signed({{(c_ACCW-XW){1'b0}}, r_x});
    assign w_ye = $signed({{(c_ACCW-YW){1'b0}}, r_y});

    // Shoelace term x*dy - y*dx with unit steps reduces to add/subtract
    always_comb begin
        w_dacc = '0;
        if (w_yp)      w_dacc = w_dacc + w_xe;
        else if (w_yn) w_dacc = w_dacc - w_xe;
        if (w_xp)      w_dacc = w_dacc - w_ye;
        else if (w_xn) w_dacc = w_dacc + w_ye;
    end

    assign w_abs = r_acc[c_ACCW-1] ? $unsigned(-r_acc) : $unsigned(r_acc);
    assign Area  = r_area;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_area <= '0;
        end else begin
            if ((r_state == c_IDLE) && start) begin
                r_acc  <= '0;
                r_area <= '0;
            end
            if (w_hit) r_acc <= r_acc + w_dacc;
            if ((w_state_nxt == c_DONE) && (r_state != c_DONE)) r_area <= AW'(w_abs >> 1);
        end
    end
`else
    assign Area = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chain_code_tracer.sv
`default_nettype none
// ============================================================================
// Module      : tb_chain_code_tracer
// Description : Randomised self-checking bench for chain_code_tracer against
//               an image-level border-following reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chain_code_tracer;

    localparam int XW = 6;
    localparam int YW = 6;
    localparam int PW = 8;
    localparam int AW = 12;
    localparam int NX = 1 << XW;
    localparam int NY = 1 << YW;

    logic              Clk = 1'b0;
    logic              reset;
    logic              start;
    logic [YW+XW-1:0]  pix_addr;
    logic              pix_rd;
    logic              pix_data;
    logic [2:0]        Code;
    logic              code_valid;
    logic              code_ready;
    logic [XW-1:0]     start_x;
    logic [YW-1:0]     start_y;
    logic [AW-1:0]     Area;
    logic [PW-1:0]     Perimiter;
    logic              Done;
    logic              Error;

    chain_code_tracer #(.XW(XW), .YW(YW), .PW(PW), .AW(AW)) u_dut (
        .Clk        (Clk),
        .reset      (reset),
        .start      (start),
        .pix_addr   (pix_addr),
        .pix_rd     (pix_rd),
        .pix_data   (pix_data),
        .Code       (Code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .start_x    (start_x),
        .start_y    (start_y),
        .Area       (Area),
        .Perimiter  (Perimiter),
        .Done       (Done),
        .Error      (Error)
    );

    always #5 Clk = ~Clk;

    // Frame buffer with one-cycle read latency
    logic [NX-1:0] img [NY];
    always @(posedge Clk) pix_data <= pix_rd ? img[pix_addr[XW+YW-1:XW]][pix_addr[XW-1:0]] : 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    int n_valid;
    int last_cycles;

    int DX [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int DY [8] = '{0, -1, -1, -1, 0, 1, 1, 1};

    int m_codes [$];
    int d_codes [$];
    int q_sq    [$];
    int m_sx, m_sy, m_area, m_done, m_err, m_found;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int y = 0; y < NY; y++) img[y] = '0;
    endtask

    task automatic set_rect(input int x0, input int y0, input int w, input int h);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                if (x < NX && y < NY) img[y][x] = 1'b1;
    endtask

    // Reference: walk the image directly with integer coordinates
    task automatic model_run();
        int cx, cy, s, nbg, nx, ny, acc, a;
        bit obj;
        m_codes.delete();
        m_done = 0; m_err = 0; m_area = 0; m_found = 0; m_sx = 0; m_sy = 0;
        for (int y = 0; y < NY && m_found == 0; y++)
            for (int x = 0; x < NX && m_found == 0; x++)
                if (img[y][x]) begin m_found = 1; m_sx = x; m_sy = y; end
        if (m_found == 0) begin
            m_err = 1;
            return;
        end
        cx = m_sx; cy = m_sy; s = 5; nbg = 0; acc = 0;
        while (m_done == 0 && m_err == 0) begin
            nx = cx + DX[s];
            ny = cy + DY[s];
            obj = 1'b0;
            if (nx >= 0 && nx < NX && ny >= 0 && ny < NY) obj = img[ny][nx];
            if (!obj) begin
                s = (s + 1) % 8;
                nbg++;
                if (nbg == 8) m_done = 1;
            end else if (m_codes.size() == (1 << PW) - 1) begin
                m_err = 1;
            end else begin
                m_codes.push_back(s);
                acc += cx * DY[s] - cy * DX[s];
                cx = nx; cy = ny;
                s = (s % 2 == 0) ? (s + 7) % 8 : (s + 6) % 8;
                nbg = 0;
                if (cx == m_sx && cy == m_sy) m_done = 1;
            end
        end
        a = (acc < 0) ? -acc : acc;
`ifdef CC_AREA_EN
        if (m_done != 0) m_area = (a >> 1) % (1 << AW);
`else
        if (a < 0) m_area = 0;
`endif
    endtask

    // mode 0: always ready, 1: random ready, 2: five-cycle stall on third code
    task automatic collect(input int mode, input int budget, output int cycles);
        int  stall;
        bit  rdy;
        stall = 0;
        cycles = 0;
        n_valid = 0;
        d_codes.delete();
        while (1) begin
            @(posedge Clk);
            cycles++;
            @(negedge Clk);
            if (Done || Error) break;
            if (cycles >= budget) begin
                chk("timeout", int'(Done | Error), 1);
                break;
            end
            if (code_valid) n_valid++;
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && stall < 5 && (stall > 0 || (code_valid && d_codes.size() == 2))) begin
                rdy = 1'b0;
                stall++;
                chk("stall_valid", int'(code_valid), 1);
                chk("stall_code", int'(Code), m_codes[2]);
            end
            code_ready = rdy;
            if (code_valid && rdy) d_codes.push_back(int'(Code));
        end
        code_ready = 1'b1;
        chk("both_flags", int'(Done & Error), 0);
    endtask

    task automatic compare(input string name);
        chk({name, "_done"}, int'(Done), m_done);
        chk({name, "_err"}, int'(Error), m_err);
        chk({name, "_perim"}, int'(Perimiter), m_codes.size());
        chk({name, "_ncodes"}, d_codes.size(), m_codes.size());
        if (m_found != 0) begin
            chk({name, "_sx"}, int'(start_x), m_sx);
            chk({name, "_sy"}, int'(start_y), m_sy);
        end
        if (m_done != 0) chk({name, "_area"}, int'(Area), m_area);
        for (int i = 0; i < d_codes.size() && i < m_codes.size(); i++)
            chk({name, "_code"}, d_codes[i], m_codes[i]);
    endtask

    task automatic finish_run();
        start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("idle_flags", int'(Done | Error), 0);
    endtask

    task automatic run_case(input string name, input int mode);
        int cyc;
        model_run();
        @(negedge Clk);
        start = 1'b1;
        collect(mode, 30000, cyc);
        last_cycles = cyc;
        compare(name);
        finish_run();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, int'(pix_addr), 0);
        chk({tag, "_rd"}, int'(pix_rd), 0);
        chk({tag, "_code"}, int'(Code), 0);
        chk({tag, "_valid"}, int'(code_valid), 0);
        chk({tag, "_sx"}, int'(start_x), 0);
        chk({tag, "_sy"}, int'(start_y), 0);
        chk({tag, "_area"}, int'(Area), 0);
        chk({tag, "_perim"}, int'(Perimiter), 0);
        chk({tag, "_done"}, int'(Done), 0);
        chk({tag, "_err"}, int'(Error), 0);
    endtask

    initial begin
        int cyc;
        int waited;
        reset = 1'b1;
        start = 1'b0;
        code_ready = 1'b1;
        clear_img();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_zero("rst");
        reset = 1'b0;

        // Blank frame: full scan then error, no codes
        clear_img();
        run_case("blank", 0);
        chk("blank_cycles", last_cycles, 2 * NX * NY + 1);
        chk("blank_valid", n_valid, 0);

        // Isolated pixel
        clear_img();
        set_rect(5, 3, 1, 1);
        run_case("single", 0);

        // 3x3 square, unstalled then stalled
        clear_img();
        set_rect(10, 10, 3, 3);
        run_case("square", 0);
`ifdef CC_AREA_EN
        chk("square_area4", int'(Area), 4);
`endif
        q_sq = d_codes;
        run_case("stall", 2);
        chk("stall_len", d_codes.size(), q_sq.size());
        for (int i = 0; i < d_codes.size() && i < q_sq.size(); i++)
            chk("stall_vs_free", d_codes[i], q_sq[i]);

        // Comb shape whose border exceeds the code counter
        clear_img();
        set_rect(0, 10, 63, 1);
        for (int x = 0; x < 63; x += 2) set_rect(x, 11, 1, 10);
        run_case("comb", 1);

        // Reset in the middle of a trace with start held high
        clear_img();
        set_rect(10, 10, 3, 3);
        model_run();
        @(negedge Clk);
        start = 1'b1;
        waited = 0;
        while (int'(Perimiter) != 2 && waited < 5000) begin
            @(negedge Clk);
            waited++;
        end
        chk("reach_trace", int'(Perimiter), 2);
        reset = 1'b1;
        @(negedge Clk);
        chk_zero("midrst");
        reset = 1'b0;
        collect(0, 30000, cyc);
        compare("rerun");
        finish_run();

        // Random rectangle unions with random back-pressure
        for (int r = 0; r < 6; r++) begin
            clear_img();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                set_rect($urandom_range(0, NX - 1), $urandom_range(0, NY - 1),
                         $urandom_range(1, 10), $urandom_range(1, 10));
            run_case("rand", 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
